// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stalls, branch flushes and memory-busy freezes for a 5-stage MIPS pipeline
module hazard_stall_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int WAIT_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             ID_EX_MemRead_in,
  input  logic [4:0]       ID_EX_Rt_in,
  input  logic [4:0]       IF_ID_Rs_in,
  input  logic [4:0]       IF_ID_Rt_in,
  input  logic             IF_ID_Uses_Rt_in,
  input  logic             branch_taken_in,
  input  logic             mem_busy_in,
  output logic             PC_Write_out,
  output logic             IF_ID_Write_out,
  output logic             IF_ID_Flush_out,
  output logic             ID_EX_Bubble_out,
  output logic             freeze_out,
  output logic [CNT_W-1:0] stall_cycles_out,
  output logic             err_timeout_out
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [3:0] fcnt, fcnt_n;
  logic [9:0] wcnt, wcnt_n;
  logic resume_flush, resume_n, err_n, hazard, in_flush;
  assign hazard = ID_EX_MemRead_in && ID_EX_Rt_in != 5'd0 &&
                  (ID_EX_Rt_in == IF_ID_Rs_in || (IF_ID_Uses_Rt_in && ID_EX_Rt_in == IF_ID_Rt_in));
  assign in_flush = state == FLUSH;
  // Memory busy wins over everything but reset; hazard is only honoured in RUN without a branch
  assign freeze_out = !reset_in && (state == MEM_WAIT || mem_busy_in);
  assign IF_ID_Flush_out = reset_in || (!freeze_out && (in_flush || branch_taken_in));
  assign ID_EX_Bubble_out = reset_in || (!freeze_out && (in_flush || branch_taken_in || hazard));
  assign PC_Write_out = !reset_in && !freeze_out && (in_flush || branch_taken_in || !hazard);
  assign IF_ID_Write_out = PC_Write_out;
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    wcnt_n = wcnt;
    resume_n = resume_flush;
    if (state == MEM_WAIT) begin
      if (mem_busy_in) wcnt_n = &wcnt ? wcnt : wcnt + 10'd1;
      else begin
        state_n = resume_flush ? FLUSH : RUN;
        wcnt_n = 10'd0;
      end
    end else if (mem_busy_in) begin
      state_n = MEM_WAIT;
      wcnt_n = 10'd1;
      resume_n = in_flush;
    end else if (in_flush) begin
      fcnt_n = fcnt - 4'd1;
      state_n = fcnt <= 4'd1 ? RUN : FLUSH;
    end else if (branch_taken_in && BRANCH_PENALTY > 1) begin
      state_n = FLUSH;
      fcnt_n = 4'(BRANCH_PENALTY - 1);
    end
    err_n = err_timeout_out || (state == MEM_WAIT && mem_busy_in && wcnt_n >= 10'(WAIT_TIMEOUT));
  end
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state <= RUN;
      fcnt <= '0;
      wcnt <= '0;
      resume_flush <= 1'b0;
      err_timeout_out <= 1'b0;
      stall_cycles_out <= '0;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      wcnt <= wcnt_n;
      resume_flush <= resume_n;
      err_timeout_out <= err_n;
      if (!PC_Write_out && !(&stall_cycles_out)) stall_cycles_out <= stall_cycles_out + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: two differently parameterised controllers checked against a rule-level model
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic reset_in, mr, uses, br, busy;
  logic [4:0] ert, rs, irt;
  logic [1:0] pcw, ifw, fl, bu, fr, er;
  logic [15:0] st0;
  logic [2:0] st1;
  int checks = 0, fails = 0;
  int fl_cnt[2], fr_cnt[2];
  bit started = 0;
  int pen[2] = '{3, 2};
  int tmo[2] = '{4, 6};
  int mx[2] = '{65535, 7};
  int fleft[2], wlen[2], stalls[2];
  bit inw[2], err[2];
  logic hz;
  logic [3:0] e;
  logic [31:0] st;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.BRANCH_PENALTY(3), .WAIT_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset_in(reset_in), .ID_EX_MemRead_in(mr), .ID_EX_Rt_in(ert),
    .IF_ID_Rs_in(rs), .IF_ID_Rt_in(irt), .IF_ID_Uses_Rt_in(uses), .branch_taken_in(br),
    .mem_busy_in(busy), .PC_Write_out(pcw[0]), .IF_ID_Write_out(ifw[0]), .IF_ID_Flush_out(fl[0]),
    .ID_EX_Bubble_out(bu[0]), .freeze_out(fr[0]), .stall_cycles_out(st0), .err_timeout_out(er[0]));

  hazard_stall_ctrl #(.BRANCH_PENALTY(2), .WAIT_TIMEOUT(6), .CNT_W(3)) dut2 (
    .clk(clk), .reset_in(reset_in), .ID_EX_MemRead_in(mr), .ID_EX_Rt_in(ert),
    .IF_ID_Rs_in(rs), .IF_ID_Rt_in(irt), .IF_ID_Uses_Rt_in(uses), .branch_taken_in(br),
    .mem_busy_in(busy), .PC_Write_out(pcw[1]), .IF_ID_Write_out(ifw[1]), .IF_ID_Flush_out(fl[1]),
    .ID_EX_Bubble_out(bu[1]), .freeze_out(fr[1]), .stall_cycles_out(st1), .err_timeout_out(er[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs come from the priority rules; the model tracks owed flush cycles and wait length
  always @(negedge clk) if (started) for (int i = 0; i < 2; i++) begin
    hz = mr && ert != 0 && (ert == rs || (uses && ert == irt));
    if (reset_in) e = 4'b0110;
    else if (inw[i] || busy) e = 4'b0001;
    else if (fleft[i] > 0 || br) e = 4'b1110;
    else if (hz) e = 4'b0010;
    else e = 4'b1000;
    st = i ? 32'(st1) : 32'(st0);
    chk($sformatf("pc_write[%0d]", i), pcw[i], e[3]);
    chk($sformatf("if_id_write[%0d]", i), ifw[i], e[3]);
    chk($sformatf("flush[%0d]", i), fl[i], e[2]);
    chk($sformatf("bubble[%0d]", i), bu[i], e[1]);
    chk($sformatf("freeze[%0d]", i), fr[i], e[0]);
    chk($sformatf("err[%0d]", i), er[i], err[i]);
    chk($sformatf("stalls[%0d]", i), st, stalls[i]);
    if (!reset_in) begin
      fl_cnt[i] += int'(fl[i]);
      fr_cnt[i] += int'(fr[i]);
    end
    if (reset_in) begin
      fleft[i] = 0; inw[i] = 0; wlen[i] = 0; err[i] = 0; stalls[i] = 0;
    end else begin
      if (!e[3] && stalls[i] < mx[i]) stalls[i]++;
      if (inw[i]) begin
        if (busy) begin
          if (wlen[i] < 1023) wlen[i]++;
          if (wlen[i] >= tmo[i]) err[i] = 1;
        end else begin
          inw[i] = 0; wlen[i] = 0;
        end
      end else if (busy) begin
        inw[i] = 1; wlen[i] = 1;
      end else if (fleft[i] > 0) fleft[i]--;
      else if (br) fleft[i] = pen[i] - 1;
    end
  end

  task automatic step(input logic r, m, input logic [4:0] et, s, t, input logic u, b, bz);
    reset_in = r; mr = m; ert = et; rs = s; irt = t; uses = u; br = b; busy = bz;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_busy(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rst();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    fl_cnt = '{0, 0};
    fr_cnt = '{0, 0};
  endtask

  initial begin
    reset_in = 1; mr = 0; ert = 0; rs = 0; irt = 0; uses = 0; br = 0; busy = 0;
    @(posedge clk);
    #1;
    started = 1;
    rst();
    chk("reset_stalls", st0, 0);
    chk("reset_err", er[0], 0);
    idle(1);
    step(0, 1, 5, 5, 0, 0, 0, 0);
    idle(1);
    chk("hazard_stalls", st0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 7, 3, 7, 0, 0, 0);
    chk("no_stall_r0_unused_rt", st0, 1);
    step(0, 1, 7, 3, 7, 1, 0, 0);
    idle(1);
    chk("rt_stall", st0, 2);
    rst();
    step(0, 1, 5, 5, 0, 0, 1, 0);
    idle(5);
    chk("branch_flush_p3", fl_cnt[0], 3);
    chk("branch_flush_p2", fl_cnt[1], 2);
    chk("branch_no_stall", st0, 0);
    rst();
    wait_busy(5);
    idle(3);
    chk("mem_freeze0", fr_cnt[0], 6);
    chk("mem_freeze1", fr_cnt[1], 6);
    chk("mem_stalls", st0, 6);
    chk("mem_err_t4", er[0], 1);
    chk("mem_err_t6", er[1], 0);
    rst();
    step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(4);
    chk("busy_branch_noflush", fl_cnt[0], 0);
    chk("busy_branch_freeze", fr_cnt[0], 2);
    rst();
    step(0, 0, 0, 0, 0, 0, 1, 0);
    wait_busy(3);
    idle(5);
    chk("wait_in_flush_p3", fl_cnt[0], 3);
    chk("wait_in_flush_p2", fl_cnt[1], 2);
    chk("wait_in_flush_freeze", fr_cnt[0], 4);
    rst();
    wait_busy(3);
    chk("timeout_before", er[0], 0);
    wait_busy(1);
    chk("timeout_set", er[0], 1);
    wait_busy(2);
    reset_in = 1;
    #2;
    chk("rst_pc_write", pcw[0], 0);
    chk("rst_flush", fl[0], 1);
    chk("rst_bubble", bu[0], 1);
    chk("rst_freeze", fr[0], 0);
    @(posedge clk);
    #1;
    chk("rst_err_clear", er[0], 0);
    chk("rst_stalls_clear", st0, 0);
    reset_in = 0; busy = 0;
    #2;
    chk("rst_resume_run", pcw[0], 1);
    @(posedge clk);
    #1;
    rst();
    wait_busy(9);
    idle(2);
    chk("sat_narrow", st1, 7);
    chk("sat_wide", st0, 10);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
